dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL take parameter DEPTH, default 256, giving the memory size in 64-bit doublewords (power of two).
REQ-002 The module SHALL take parameter LATENCY, default 2, giving the number of wait cycles between request accept and response (0..15).
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  reset, asynchronous and active-high.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  responder can accept a request.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_size  in  3  RISC-V funct3 of the load or store.
REQ-009 req_addr  in  64  byte address.
REQ-010 req_wdata  in  64  store data, right-aligned.
REQ-011 resp_valid  out  1  one-cycle response strobe.
REQ-012 resp_rdata  out  64  load result, extended to 64 bits.
REQ-013 resp_error  out  1  request rejected; valid only with resp_valid.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted when req_valid and req_ready are both 1, with write, size, addr and wdata captured that cycle.
REQ-016 Accept SHALL go to WAIT when LATENCY>0, or to RESP when LATENCY=0; WAIT SHALL load a down-counter with LATENCY-1 and move to RESP when the counter reaches 0.
REQ-017 Memory access (read sample or write commit) SHALL happen on the edge that enters RESP; resp_valid SHALL be 1 for exactly the one RESP cycle; RESP SHALL always return to IDLE.
REQ-018 Total latency from accept edge to resp_valid high SHALL be LATENCY+1 cycles; there is no response backpressure.
REQ-019 Word index SHALL be addr[63:3] modulo DEPTH; upper address bits SHALL be ignored, so accesses wrap.
REQ-020 Loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; lb/lh/lw SHALL sign-extend and lbu/lhu/lwu SHALL zero-extend.
REQ-021 Stores: 000 sb, 001 sh, 010 sw, 011 sd; stores SHALL update only the addressed byte lanes.
REQ-022 Any other size, or an address not aligned to the access size, SHALL give resp_error=1 and resp_rdata=0, with no memory write.
REQ-023 Stores SHALL return resp_rdata=0.
REQ-024 resp_rdata and resp_error SHALL be 0 whenever resp_valid is 0.
REQ-025 req_valid asserted outside IDLE SHALL be ignored (not queued).

Reset
REQ-026 Reset SHALL force IDLE and a zero counter, and drive req_ready=1, resp_valid=0, resp_rdata=0 and resp_error=0.
REQ-027 Reset mid-transaction SHALL abort it: a pending store SHALL NOT be committed.
REQ-028 Memory contents SHALL NOT be reset.

Structure
REQ-029 The funct3 load/store size encodings SHALL be added as a named typedef to the shared operations package; the FSM state enum SHALL stay local to the module.
REQ-030 Byte-lane alignment, store byte enables and load extension SHALL live in one combinational sub-module, dmem_lane_align.
REQ-031 The memory array SHALL be an internal register array of DEPTH x 64 bits.

Verification
REQ-032 sd addr 0x10 data 0x8877665544332211, then ld 0x10 -> rdata 0x8877665544332211, error 0, resp_valid exactly LATENCY+1 cycles after each accept.
REQ-033 After REQ-032: lb 0x17 -> 0xFFFFFFFFFFFFFF88; lbu 0x17 -> 0x88; lh 0x16 -> 0xFFFFFFFFFFFF8877; lwu 0x14 -> 0x88776655.
REQ-034 sb 0x11 data 0xAB, then ld 0x10 -> 0x887766554433AB11 (other lanes unchanged).
REQ-035 lw 0x12 -> error 1, rdata 0; sw 0x13 -> error 1, with memory unchanged; size 111 -> error 1.
REQ-036 Wrap with DEPTH=256: sd to 0x800 (index 0), then ld 0x0 -> same data; req_valid held through WAIT -> exactly one response per accept.
REQ-037 reset asserted in WAIT of sd 0x20 -> next cycle req_ready=1, resp_valid=0, and a later ld 0x20 returns the prior contents; repeat with LATENCY=0 -> response on the cycle after accept.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared operation types for the data-memory responder: RISC-V funct3 access sizes
// and small helpers for legality and alignment of an access.
package dmem_responder_pkg;

    typedef enum logic [2:0] {
        SZ_B   = 3'b000,
        SZ_H   = 3'b001,
        SZ_W   = 3'b010,
        SZ_D   = 3'b011,
        SZ_BU  = 3'b100,
        SZ_HU  = 3'b101,
        SZ_WU  = 3'b110,
        SZ_RSV = 3'b111
    } mem_size_e;

    // Stores only have signed encodings; loads accept everything except 111.
    function automatic logic size_legal(input logic write, input mem_size_e sz);
        if (write) return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W) || (sz == SZ_D);
        return sz != SZ_RSV;
    endfunction

    function automatic logic size_aligned(input mem_size_e sz, input logic [2:0] off);
        case (sz[1:0])
            2'd0:    return 1'b1;
            2'd1:    return off[0] == 1'b0;
            2'd2:    return off[1:0] == 2'b00;
            default: return off == 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane handling for one doubleword access: store merge and byte enables,
// load extraction with sign/zero extension, and rejection of illegal accesses.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic        write_i,
    input  logic [2:0]  size_i,
    input  logic [2:0]  off_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rword_i,
    output logic [63:0] wword_o,
    output logic [7:0]  be_o,
    output logic [63:0] rdata_o,
    output logic        err_o
);

    mem_size_e   sz;
    logic [63:0] wshift;
    logic [63:0] rshift;

    assign sz     = mem_size_e'(size_i);
    assign err_o  = !size_legal(write_i, sz) || !size_aligned(sz, off_i);
    assign wshift = wdata_i << {off_i, 3'b000};
    assign rshift = rword_i >> {off_i, 3'b000};

    always_comb begin
        be_o = 8'h00;
        if (write_i && !err_o) begin
            case (sz[1:0])
                2'd0:    be_o = 8'h01 << off_i;
                2'd1:    be_o = 8'h03 << off_i;
                2'd2:    be_o = 8'h0F << off_i;
                default: be_o = 8'hFF;
            endcase
        end
    end

    // Untouched lanes keep the current word so the whole doubleword can be written back.
    always_comb begin
        wword_o = rword_i;
        for (int b = 0; b < 8; b++) begin
            if (be_o[b]) wword_o[8*b +: 8] = wshift[8*b +: 8];
        end
    end

    always_comb begin
        rdata_o = 64'd0;
        if (!write_i && !err_o) begin
            case (sz)
                SZ_B:    rdata_o = {{56{rshift[7]}},  rshift[7:0]};
                SZ_H:    rdata_o = {{48{rshift[15]}}, rshift[15:0]};
                SZ_W:    rdata_o = {{32{rshift[31]}}, rshift[31:0]};
                SZ_D:    rdata_o = rshift;
                SZ_BU:   rdata_o = {56'd0, rshift[7:0]};
                SZ_HU:   rdata_o = {48'd0, rshift[15:0]};
                SZ_WU:   rdata_o = {32'd0, rshift[31:0]};
                default: rdata_o = 64'd0;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
// One request at a time: IDLE accepts, WAIT counts down, RESP strobes the result.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [2:0]  req_size_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [63:0] resp_rdata_o,
    output logic        resp_error_o
);

    localparam int         IDXW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         AW       = IDXW + 3;
    localparam bit         DIRECT   = (LATENCY == 0);
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e         state_q;
    logic [3:0]     cnt_q;
    logic           write_q;
    logic [2:0]     size_q;
    logic [AW-1:0]  addr_q;
    logic [63:0]    wdata_q;
    logic           ready_q;
    logic           rvalid_q;
    logic [63:0]    rdata_q;
    logic           rerr_q;

    logic [63:0]    mem_q [DEPTH];

    logic           accept;
    logic           enter_resp;
    logic           acc_write;
    logic [2:0]     acc_size;
    logic [AW-1:0]  acc_addr;
    logic [63:0]    acc_wdata;
    logic [IDXW-1:0] idx;
    logic [63:0]    rword;
    logic [63:0]    mem_d;
    logic [7:0]     be;
    logic [63:0]    al_rdata;
    logic           al_err;
    logic           unused_addr;

    assign accept     = req_valid_i && ready_q;
    assign enter_resp = (state_q == IDLE && accept && DIRECT) || (state_q == WAIT && cnt_q == 4'd0);

    // With zero latency the access happens on the accept edge, so use the live request.
    assign acc_write = DIRECT ? req_write_i          : write_q;
    assign acc_size  = DIRECT ? req_size_i           : size_q;
    assign acc_addr  = DIRECT ? req_addr_i[AW-1:0]   : addr_q;
    assign acc_wdata = DIRECT ? req_wdata_i          : wdata_q;

    assign idx   = acc_addr[AW-1:3];
    assign rword = mem_q[idx];
    assign unused_addr = ^req_addr_i[63:AW];

    dmem_lane_align u_align (
        .write_i (acc_write),
        .size_i  (acc_size),
        .off_i   (acc_addr[2:0]),
        .wdata_i (acc_wdata),
        .rword_i (rword),
        .wword_o (mem_d),
        .be_o    (be),
        .rdata_o (al_rdata),
        .err_o   (al_err)
    );

    // Memory contents survive reset; reset only blocks a commit that would race it.
    always_ff @(posedge clk_i) begin
        if (enter_resp && !reset_i && |be) mem_q[idx] <= mem_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 64'd0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= 64'd0;
            rerr_q   <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            rdata_q  <= 64'd0;
            rerr_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q <= req_write_i;
                        size_q  <= req_size_i;
                        addr_q  <= req_addr_i[AW-1:0];
                        wdata_q <= req_wdata_i;
                        ready_q <= 1'b0;
                        if (DIRECT) begin
                            state_q  <= RESP;
                            rvalid_q <= 1'b1;
                            rdata_q  <= al_rdata;
                            rerr_q   <= al_err;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= al_rdata;
                        rerr_q   <= al_err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = rvalid_q;
    assign resp_rdata_o = rdata_q;
    assign resp_error_o = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus random checks of two responders (LATENCY 2 and 0) against a
// byte-addressed reference memory model kept in the bench.
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [2:0]  req_size   [2];
    logic [63:0] req_addr   [2];
    logic [63:0] req_wdata  [2];
    logic        resp_valid [2];
    logic [63:0] resp_rdata [2];
    logic        resp_error [2];

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] mdl [2][DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
        .clk_i(clk), .reset_i(reset[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_write_i(req_write[0]), .req_size_i(req_size[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
        .resp_valid_o(resp_valid[0]), .resp_rdata_o(resp_rdata[0]),
        .resp_error_o(resp_error[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
        .clk_i(clk), .reset_i(reset[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_write_i(req_write[1]), .req_size_i(req_size[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
        .resp_valid_o(resp_valid[1]), .resp_rdata_o(resp_rdata[1]),
        .resp_error_o(resp_error[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, word index wraps modulo DEPTH.
    task automatic ref_op(input int d, input logic w, input logic [2:0] sz, input logic [63:0] a,
                          input logic [63:0] wd, output logic [63:0] rd, output logic er);
        int nb, off, idx;
        logic [63:0] v, mask;
        nb  = 1 << sz[1:0];
        off = int'(a % 64'd8);
        idx = int'((a / 64'd8) % DEPTH);
        er  = (w ? (sz > 3'd3) : (sz == 3'd7)) || (off % nb != 0);
        rd  = 64'd0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < nb; i++) mdl[d][idx][8*(off+i) +: 8] = wd[8*i +: 8];
            end else begin
                v = mdl[d][idx] >> (8 * off);
                if (nb < 8) begin
                    mask = (64'd1 << (8 * nb)) - 64'd1;
                    v = v & mask;
                    if (sz < 3'd3 && v[8*nb-1]) v = v | ~mask;
                end
                rd = v;
            end
        end
    endtask

    // Issue one request at a negedge; returns the observed response.
    task automatic do_req(input int d, input logic w, input logic [2:0] sz, input logic [63:0] a,
                          input logic [63:0] wd, input bit hold, input string tag,
                          output logic [63:0] got_rd, output logic got_er);
        int t;
        logic [63:0] exp_rd;
        logic exp_er;
        t = 0;
        while (!req_ready[d] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_ready"}, 64'(req_ready[d]), 64'd1);
        ref_op(d, w, sz, a, wd, exp_rd, exp_er);
        req_valid[d] = 1'b1;
        req_write[d] = w;
        req_size[d]  = sz;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        t = 0;
        got_rd = 64'd0;
        got_er = 1'b0;
        while (t <= 20) begin
            @(negedge clk);
            t++;
            if (!hold) req_valid[d] = 1'b0;
            if (resp_valid[d]) break;
            chk({tag, "_idle_out"}, {resp_rdata[d][62:0], resp_error[d]}, 64'd0);
        end
        req_valid[d] = 1'b0;
        chk({tag, "_latency"}, 64'(t), 64'(lat(d) + 1));
        got_rd = resp_rdata[d];
        got_er = resp_error[d];
        chk({tag, "_rdata"}, got_rd, exp_rd);
        chk({tag, "_error"}, 64'(got_er), 64'(exp_er));
        @(negedge clk);
        chk({tag, "_single"}, 64'(resp_valid[d]), 64'd0);
    endtask

    initial begin
        logic [63:0] rd, prior;
        logic er;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
            req_size[d] = 3'd0; req_addr[d] = 64'd0; req_wdata[d] = 64'd0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 64'(req_ready[d]), 64'd1);
            chk("rst_rvalid", 64'(resp_valid[d]), 64'd0);
            chk("rst_rdata", resp_rdata[d], 64'd0);
            chk("rst_rerr", 64'(resp_error[d]), 64'd0);
            reset[d] = 1'b0;
        end
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++)
                do_req(d, 1'b1, 3'd3, 64'(i * 8), {$urandom(), $urandom()}, 1'b0, "init", rd, er);

            do_req(d, 1'b1, 3'd3, 64'h10, 64'h8877665544332211, 1'b0, "sd10", rd, er);
            chk("sd10_zero", rd, 64'd0);
            do_req(d, 1'b0, 3'd3, 64'h10, 64'd0, 1'b0, "ld10", rd, er);
            chk("ld10_val", rd, 64'h8877665544332211);
            do_req(d, 1'b0, 3'd0, 64'h17, 64'd0, 1'b0, "lb17", rd, er);
            chk("lb17_val", rd, 64'hFFFFFFFFFFFFFF88);
            do_req(d, 1'b0, 3'd4, 64'h17, 64'd0, 1'b0, "lbu17", rd, er);
            chk("lbu17_val", rd, 64'h88);
            do_req(d, 1'b0, 3'd1, 64'h16, 64'd0, 1'b0, "lh16", rd, er);
            chk("lh16_val", rd, 64'hFFFFFFFFFFFF8877);
            do_req(d, 1'b0, 3'd6, 64'h14, 64'd0, 1'b0, "lwu14", rd, er);
            chk("lwu14_val", rd, 64'h88776655);
            do_req(d, 1'b1, 3'd0, 64'h11, 64'hAB, 1'b0, "sb11", rd, er);
            do_req(d, 1'b0, 3'd3, 64'h10, 64'd0, 1'b0, "ld10b", rd, er);
            chk("ld10b_val", rd, 64'h887766554433AB11);
            do_req(d, 1'b0, 3'd2, 64'h12, 64'd0, 1'b0, "lw12", rd, er);
            chk("lw12_err", {rd[62:0], er}, 64'd1);
            do_req(d, 1'b1, 3'd2, 64'h13, 64'hDEADBEEF, 1'b0, "sw13", rd, er);
            chk("sw13_err", 64'(er), 64'd1);
            do_req(d, 1'b0, 3'd3, 64'h10, 64'd0, 1'b0, "ld10c", rd, er);
            chk("ld10c_val", rd, 64'h887766554433AB11);
            do_req(d, 1'b0, 3'd7, 64'h10, 64'd0, 1'b0, "sz7", rd, er);
            chk("sz7_err", {rd[62:0], er}, 64'd1);

            do_req(d, 1'b1, 3'd3, 64'h800, 64'h0123456789ABCDEF, 1'b1, "sd800", rd, er);
            do_req(d, 1'b0, 3'd3, 64'h0, 64'd0, 1'b1, "ld0", rd, er);
            chk("wrap_val", rd, 64'h0123456789ABCDEF);

            // Reset mid-transaction: the pending store must not land.
            prior = mdl[d][4];
            req_valid[d] = 1'b1; req_write[d] = 1'b1; req_size[d] = 3'd3;
            req_addr[d] = 64'h20; req_wdata[d] = ~prior;
            if (d == 0) begin
                @(negedge clk);
                req_valid[d] = 1'b0;
                chk("abort_in_wait", 64'(req_ready[d]), 64'd0);
            end
            reset[d] = 1'b1;
            #1;
            chk("abort_ready", 64'(req_ready[d]), 64'd1);
            chk("abort_rvalid", 64'(resp_valid[d]), 64'd0);
            @(negedge clk);
            req_valid[d] = 1'b0;
            reset[d] = 1'b0;
            chk("abort_next_rvalid", 64'(resp_valid[d]), 64'd0);
            @(negedge clk);
            do_req(d, 1'b0, 3'd3, 64'h20, 64'd0, 1'b0, "ld20", rd, er);
            chk("abort_prior", rd, prior);

            for (int i = 0; i < 150; i++)
                do_req(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       {$urandom(), $urandom()}, {$urandom(), $urandom()},
                       1'($urandom_range(0, 1)), "rand", rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
